// File: rtl/wb_arbiter_rr2.sv
// rtl/wb_arbiter_rr2.sv - two-master round-robin Wishbone arbiter with bus watchdog
module wb_arbiter_rr2 #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic [31:0] m0_dat_o,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] m1_dat_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LP_ONE     = CNT_W'(1);

    state_t           r_state;
    logic             r_last;
    logic [CNT_W-1:0] r_wd_cnt;

    logic w_g0;
    logic w_g1;
    logic w_stb_sel;
    logic w_hit;

    // Reset gates the grant combinationally so the slave bus drops in the reset cycle itself
    assign w_g0      = (r_state == GNT0) & ~wb_rst_i;
    assign w_g1      = (r_state == GNT1) & ~wb_rst_i;
    assign w_stb_sel = (w_g0 & m0_stb_i) | (w_g1 & m1_stb_i);
    assign w_hit     = (w_g0 | w_g1) & (r_wd_cnt == LP_TIMEOUT);

    // Arbitration FSM: grant per cyc tenure, ties go to the master not granted last
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (m0_cyc_i && (!m1_cyc_i || r_last)) begin
                        r_state <= GNT0;
                        r_last  <= 1'b0;
                    end else if (m1_cyc_i) begin
                        r_state <= GNT1;
                        r_last  <= 1'b1;
                    end
                end
                GNT0: begin
                    if (!m0_cyc_i) begin
                        r_state <= IDLE;
                    end
                end
                GNT1: begin
                    if (!m1_cyc_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Watchdog: counts stalled strobe cycles of the granted master, restarts after a timeout
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !(w_g0 || w_g1) || s_ack_i || !w_stb_sel || w_hit) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + LP_ONE;
        end
    end

    // Bus mux: route the granted master to the slave, everything else held at zero
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_dat_o = '0;
        if (w_g0) begin
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            s_we_o   = m0_we_i;
            s_cyc_o  = m0_cyc_i;
            m0_ack_o = s_ack_i & ~w_hit;
            m0_err_o = w_hit;
            m0_dat_o = s_dat_i;
        end else if (w_g1) begin
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            s_we_o   = m1_we_i;
            s_cyc_o  = m1_cyc_i;
            m1_ack_o = s_ack_i & ~w_hit;
            m1_err_o = w_hit;
            m1_dat_o = s_dat_i;
        end
        s_stb_o = w_stb_sel & ~w_hit;
    end

endmodule

// File: tb/tb_wb_arbiter_rr2.sv
// tb/tb_wb_arbiter_rr2.sv - directed self-checking bench for wb_arbiter_rr2
module tb_wb_arbiter_rr2;

    localparam logic [31:0] A0 = 32'h0100_0010;
    localparam logic [31:0] B1 = 32'h0200_0020;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rd, m1_rd;
    logic [31:0] s_adr, s_wdat;
    logic [3:0]  s_sel;
    logic        s_we, s_cyc, s_stb;
    logic        r_ack = 1'b0;
    logic [31:0] r_rdat = '0;
    logic        ack_en;
    logic [31:0] mem [16];
    logic        any_out;

    int vectors = 0;
    int miscompares = 0;
    int acks;
    int bad;

    always #5 clk = ~clk;

    wb_arbiter_rr2 #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m0_dat_o(m0_rd),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .m1_dat_o(m1_rd),
        .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_we_o(s_we),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_ack_i(r_ack), .s_dat_i(r_rdat)
    );

    assign any_out = |{m0_ack, m0_err, m0_rd, m1_ack, m1_err, m1_rd,
                       s_adr, s_wdat, s_sel, s_we, s_cyc, s_stb};

    // Slave model: single-wait-state RAM, ack one cycle after an accepted strobe
    always @(posedge clk) begin
        r_ack <= ack_en & s_cyc & s_stb & ~r_ack;
        if (s_cyc && s_stb && !r_ack) begin
            for (int b = 0; b < 4; b++) begin
                if (s_we && s_sel[b]) mem[s_adr[5:2]][8*b +: 8] <= s_wdat[8*b +: 8];
            end
            r_rdat <= mem[s_adr[5:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        rst = 1'b1; ack_en = 1'b1;
        m0_adr = '0; m0_dat = '0; m0_sel = '0; m0_we = 0; m0_cyc = 0; m0_stb = 0;
        m1_adr = '0; m1_dat = '0; m1_sel = '0; m1_we = 0; m1_cyc = 0; m1_stb = 0;
        tick; tick;
        chk("rst_outs_zero", 32'(any_out), 32'd0);
        m0_cyc = 1; m0_stb = 1; m0_adr = A0; settle;
        chk("rst_req_outs_zero", 32'(any_out), 32'd0);
        m0_cyc = 0; m0_stb = 0; rst = 1'b0;
        tick;
        chk("idle_outs_zero", 32'(any_out), 32'd0);

        // single master 0 write then read back
        m0_adr = A0; m0_dat = 32'hDEAD_BEEF; m0_sel = 4'hF; m0_we = 1; m0_cyc = 1; m0_stb = 1;
        settle;
        chk("t1_idle_stb", 32'(s_stb), 32'd0);
        tick;
        chk("t1_gnt_stb", 32'(s_stb), 32'd1);
        chk("t1_gnt_adr", s_adr, A0);
        chk("t1_gnt_wdat", s_wdat, 32'hDEAD_BEEF);
        chk("t1_gnt_we", 32'(s_we), 32'd1);
        chk("t1_no_ack_yet", 32'(m0_ack), 32'd0);
        tick;
        chk("t1_wr_ack", 32'(m0_ack), 32'd1);
        m0_we = 0; settle;
        tick;
        chk("t1_rd_wait", 32'(m0_ack), 32'd0);
        tick;
        chk("t1_rd_ack", 32'(m0_ack), 32'd1);
        chk("t1_rd_data", m0_rd, 32'hDEAD_BEEF);
        chk("t1_m1_quiet", 32'({m1_ack, m1_err} | 2'(|m1_rd)), 32'd0);
        m0_cyc = 0; m0_stb = 0;
        tick;
        chk("t1_release", 32'(any_out), 32'd0);

        // tie from reset, IDLE gap, alternation
        rst = 1'b1; tick; rst = 1'b0;
        m0_adr = A0; m1_adr = B1; m0_cyc = 1; m1_cyc = 1; settle;
        chk("t2_idle_cyc", 32'(s_cyc), 32'd0);
        tick;
        chk("t2_first_cyc", 32'(s_cyc), 32'd1);
        chk("t2_first_gnt0", s_adr, A0);
        m0_cyc = 0; settle;
        chk("t2_drop_cyc", 32'(s_cyc), 32'd0);
        tick;
        chk("t2_gap_cyc", 32'(s_cyc), 32'd0);
        chk("t2_gap_adr", s_adr, 32'd0);
        tick;
        chk("t2_gnt1", s_adr, B1);
        chk("t2_gnt1_cyc", 32'(s_cyc), 32'd1);
        m0_cyc = 1; m1_cyc = 0;
        tick;
        m1_cyc = 1; settle;
        chk("t2_gap2_cyc", 32'(s_cyc), 32'd0);
        tick;
        chk("t2_alt0", s_adr, A0);
        m0_cyc = 0;
        tick;
        m0_cyc = 1; settle;
        chk("t2_gap3_cyc", 32'(s_cyc), 32'd0);
        tick;
        chk("t2_alt1", s_adr, B1);
        m0_cyc = 0; m1_cyc = 0;
        tick; tick;

        // master 0 holds cyc over 4 strobes; master 1 byte-writes afterwards
        m0_adr = A0; m0_we = 0; m0_cyc = 1; m0_stb = 1;
        tick;
        m1_adr = A0; m1_dat = 32'h0000_AB00; m1_sel = 4'h2; m1_we = 1; m1_cyc = 1; m1_stb = 1;
        settle;
        acks = 0; bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (s_adr !== A0 || m1_ack !== 1'b0 || m1_err !== 1'b0) bad++;
            if (m0_ack === 1'b1) acks++;
            tick;
        end
        chk("t3_m0_acks", 32'(acks), 32'd4);
        chk("t3_no_interleave", 32'(bad), 32'd0);
        m0_cyc = 0; m0_stb = 0;
        tick;
        chk("t3_gap_cyc", 32'(s_cyc), 32'd0);
        tick;
        chk("t3_gnt1_adr", s_adr, A0);
        chk("t3_gnt1_sel", 32'(s_sel), 32'h2);
        chk("t3_gnt1_wdat", s_wdat, 32'h0000_AB00);
        tick;
        chk("t5_m1_ack", 32'(m1_ack), 32'd1);
        m1_cyc = 0; m1_stb = 0;
        tick;
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = A0;
        tick; tick;
        chk("t5_rd_ack", 32'(m0_ack), 32'd1);
        chk("t5_byte_merge", m0_rd, 32'hDEAD_ABEF);
        m0_cyc = 0; m0_stb = 0;
        tick; tick;

        // watchdog with slave never acking
        ack_en = 0;
        m0_cyc = 1; m0_stb = 1;
        tick;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (m0_err !== 1'b0 || s_stb !== 1'b1) bad++;
            tick;
        end
        chk("t4_pre_timeout", 32'(bad), 32'd0);
        chk("t4_err_pulse", 32'(m0_err), 32'd1);
        chk("t4_stb_forced0", 32'(s_stb), 32'd0);
        chk("t4_ack_forced0", 32'(m0_ack), 32'd0);
        chk("t4_m1_err_quiet", 32'(m1_err), 32'd0);
        tick;
        chk("t4_err_one_cycle", 32'(m0_err), 32'd0);
        chk("t4_stb_back", 32'(s_stb), 32'd1);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (m0_err !== 1'b0) bad++;
            tick;
        end
        chk("t4_restart_quiet", 32'(bad), 32'd0);
        chk("t4_err_again", 32'(m0_err), 32'd1);
        m0_cyc = 0; m0_stb = 0;
        tick; tick;

        // reset during a stalled master 1 access
        m1_adr = B1; m1_we = 0; m1_cyc = 1; m1_stb = 1;
        tick; tick; tick;
        chk("t6_stalled_stb", 32'(s_stb), 32'd1);
        rst = 1'b1; m0_adr = A0; m0_cyc = 1; settle;
        chk("t6_rst_stb_drop", 32'(s_stb), 32'd0);
        chk("t6_rst_cyc_drop", 32'(s_cyc), 32'd0);
        tick;
        rst = 1'b0; settle;
        chk("t6_idle_outs", 32'(any_out), 32'd0);
        tick;
        chk("t6_tie_gnt0", s_adr, A0);
        m0_cyc = 0; m1_cyc = 0; m1_stb = 0;
        tick; tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
